// File: rtl/sap_core_param.sv
// sap_core_param
// Parametrised SAP-style accumulator processor with a multiplexed internal
// bus and a unified RAM that is loaded through a side port while stopped.
//
// Ports:
//   clk        system clock, rising edge
//   low_clr    asynchronous active-low reset
//   run        start/resume request, sampled only while stopped
//   prog_we    RAM load strobe, honoured only while stopped
//   prog_addr  RAM load address
//   prog_data  RAM load data
//   out        output register
//   out_valid  one-cycle pulse after out is updated
//   carry_flag registered carry (no-borrow on SUB)
//   zero_flag  registered zero
//   halted     high while stopped
//   pc         program counter
//   bus        copy of the internal bus, 0 when undriven
//
// state  | meaning
// S_STOP | halted; RAM loadable; waits for run
// S_T1   | MAR <= PC
// S_T2   | PC <= PC + 1
// S_T3   | IR <= RAM[MAR]
// S_T4   | execute step 1 (HLT returns to S_STOP here)
// S_T5   | execute step 2
// S_T6   | execute step 3
module sap_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              low_clr,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_STOP, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  typedef enum logic [2:0] {
    B_ZERO, B_PC, B_RAM, B_OPR, B_A, B_ALU
  } bus_src_t;

  state_t   state_q, state_d;
  bus_src_t bus_src;

  logic ld_mar, inc_pc, ld_ir, ld_a, ld_b, ld_pc, ld_out, ld_flags, mem_we;

  logic [ADDR_W-1:0] mar_q;
  logic [3:0]        ir_op_q;
  logic [ADDR_W-1:0] ir_opr_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   alu_sum;
  logic              is_sub;

  assign ram_rd = mem[mar_q];
  assign halted = (state_q == S_STOP);

  // SUB is A + ~B + 1 at DATA_W+1 bits, so the top bit is the no-borrow flag.
  assign is_sub  = (ir_op_q == OP_SUB);
  assign b_eff   = is_sub ? ~b_q : b_q;
  assign alu_sum = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

  always_comb begin
    bus = '0;
    case (bus_src)
      B_PC:    bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
      B_RAM:   bus = ram_rd;
      B_OPR:   bus = {{(DATA_W-ADDR_W){1'b0}}, ir_opr_q};
      B_A:     bus = a_q;
      B_ALU:   bus = alu_sum[DATA_W-1:0];
      default: bus = '0;
    endcase
  end

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) state_q <= S_STOP;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bus_src  = B_ZERO;
    ld_mar   = 1'b0;
    inc_pc   = 1'b0;
    ld_ir    = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_pc    = 1'b0;
    ld_out   = 1'b0;
    ld_flags = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      S_STOP: if (run) state_d = S_T1;
      S_T1: begin
        bus_src = B_PC;
        ld_mar  = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        inc_pc  = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        bus_src = B_RAM;
        ld_ir   = 1'b1;
        state_d = S_T4;
      end
      S_T4: begin
        state_d = S_T5;
        case (ir_op_q)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            bus_src = B_OPR;
            ld_mar  = 1'b1;
          end
          OP_LDI: begin
            bus_src = B_OPR;
            ld_a    = 1'b1;
          end
          OP_JMP: begin
            bus_src = B_OPR;
            ld_pc   = 1'b1;
          end
          OP_JC: begin
            bus_src = B_OPR;
            ld_pc   = carry_flag;
          end
          OP_JZ: begin
            bus_src = B_OPR;
            ld_pc   = zero_flag;
          end
          OP_OUT: begin
            bus_src = B_A;
            ld_out  = 1'b1;
          end
          OP_HLT:  state_d = S_STOP;
          default: ;
        endcase
      end
      S_T5: begin
        state_d = S_T6;
        case (ir_op_q)
          OP_LDA: begin
            bus_src = B_RAM;
            ld_a    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_src = B_RAM;
            ld_b    = 1'b1;
          end
          OP_STA: begin
            bus_src = B_A;
            mem_we  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        state_d = S_T1;
        if (ir_op_q == OP_ADD || ir_op_q == OP_SUB) begin
          bus_src  = B_ALU;
          ld_a     = 1'b1;
          ld_flags = 1'b1;
        end
      end
      default: state_d = S_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      pc         <= '0;
      mar_q      <= '0;
      ir_op_q    <= '0;
      ir_opr_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      out_valid <= ld_out;
      if (ld_mar) mar_q <= bus[ADDR_W-1:0];
      if (inc_pc) pc <= pc + ADDR_W'(1);
      else if (ld_pc) pc <= bus[ADDR_W-1:0];
      if (ld_ir) begin
        ir_op_q  <= bus[DATA_W-1 -: 4];
        ir_opr_q <= bus[ADDR_W-1:0];
      end
      if (ld_a)   a_q <= bus;
      if (ld_b)   b_q <= bus;
      if (ld_out) out <= bus;
      if (ld_flags) begin
        carry_flag <= alu_sum[DATA_W];
        zero_flag  <= (alu_sum[DATA_W-1:0] == '0);
      end
    end
  end

  // RAM keeps its contents through reset. The store strobe is decoded from
  // the state register, so an asynchronous reset mid-STA suppresses the write.
  always_ff @(posedge clk) begin
    if (halted && prog_we) mem[prog_addr] <= prog_data;
    else if (mem_we)       mem[mar_q]     <= bus;
  end

endmodule
